eccop_amm_arb: RTL and testbench

//  Round-robin, job-locking arbiter that shares one eccop_amm slave among P_NM AvalonMM masters.
//  A master locks the slave for a whole job: operand load, start, poll, result read.

---
 rtl/eccop_amm_arb_pkg.sv | 8 +
 rtl/eccop_amm_arb_if.sv | 34 +++
 rtl/eccop_amm_arb_rr_pick.sv | 25 ++
 rtl/eccop_amm_arb.sv | 141 ++++++++++++++
 tb/tb_eccop_amm_arb.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/eccop_amm_arb_pkg.sv
// eccop_arb_pkg: shared FSM states and widths for the eccop_amm arbiter
package eccop_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN, HOLD} state_t;
    // Owner index width is sized for the largest supported master count (8)
    localparam int P_NM_MAX = 8;
    localparam int P_IDXW = $clog2(P_NM_MAX);
    localparam int CNT_W = 16;
endpackage

// File: rtl/eccop_amm_arb_if.sv
// eccop_amm_arb_if: per-master AvalonMM request side plus the shared eccop_amm slave side
interface eccop_amm_arb_if #(parameter int P_NM = 2);
    logic [P_NM-1:0]    m_req;
    logic [P_NM-1:0]    m_gnt;
    logic [P_NM*32-1:0] m_address;
    logic [P_NM*32-1:0] m_writedata;
    logic [P_NM-1:0]    m_write;
    logic [P_NM-1:0]    m_read;
    logic [P_NM-1:0]    m_waitrequest;
    logic [31:0]        m_readdata;
    logic [P_NM-1:0]    m_irq;
    logic [P_NM-1:0]    m_timeout;
    logic [31:0]        s_address;
    logic [31:0]        s_writedata;
    logic               s_write;
    logic               s_read;
    logic               s_waitrequest;
    logic [31:0]        s_readdata;
    logic               s_interrupt;
    // System side: drives the masters and models the eccop_amm slave
    modport master (
        output m_req, m_address, m_writedata, m_write, m_read,
        output s_waitrequest, s_readdata, s_interrupt,
        input  m_gnt, m_waitrequest, m_readdata, m_irq, m_timeout,
        input  s_address, s_writedata, s_write, s_read
    );
    // Arbiter side
    modport slave (
        input  m_req, m_address, m_writedata, m_write, m_read,
        input  s_waitrequest, s_readdata, s_interrupt,
        output m_gnt, m_waitrequest, m_readdata, m_irq, m_timeout,
        output s_address, s_writedata, s_write, s_read
    );
endinterface

// File: rtl/eccop_amm_arb_rr_pick.sv
// eccop_rr_pick: combinational round-robin picker, first requester from ptr upward with wrap
module eccop_rr_pick
    import eccop_arb_pkg::*;
#(
    parameter int P_NM = 2
) (
    input  logic [P_NM-1:0]   req_i,
    input  logic [P_IDXW-1:0] ptr_i,
    output logic              any_o,
    output logic [P_IDXW-1:0] idx_o
);
    logic [P_NM_MAX-1:0] req_w;
    logic [P_IDXW-1:0]   c;
    assign req_w = P_NM_MAX'(req_i);
    assign any_o = |req_i;
    // Scan from farthest to nearest so the nearest requester to ptr wins
    always_comb begin
        idx_o = '0;
        c = '0;
        for (int k = P_NM - 1; k >= 0; k--) begin
            c = P_IDXW'((int'(ptr_i) + k) % P_NM);
            if (req_w[c]) idx_o = c;
        end
    end
endmodule

// File: rtl/eccop_amm_arb.sv
// eccop_amm_arb: round-robin job-locking arbiter sharing one eccop_amm among P_NM masters
// Optional idle-grant revocation enabled by defining ECCOP_ARB_TIMEOUT_EN
module eccop_amm_arb
    import eccop_arb_pkg::*;
#(
    parameter int P_NM      = 2,
    parameter int P_TIMEOUT = 65535
) (
    input logic           clk,
    input logic           areset,
    input logic           sreset,
    eccop_amm_arb_if.slave bus
);
    state_t            state_q;
    logic [P_IDXW-1:0] own_q, ptr_q, pick_idx, nxt_own;
    logic [P_NM-1:0]   gnt_q;
    logic              pick_any, own_en, own_req, own_rd, own_wr, rel;

    eccop_rr_pick #(.P_NM(P_NM)) u_pick (
        .req_i (bus.m_req),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    assign own_en  = state_q == OWN;
    assign rel     = !own_req && !own_rd && !own_wr;
    assign nxt_own = (own_q == P_IDXW'(P_NM - 1)) ? '0 : own_q + 1'b1;
    assign bus.m_gnt      = gnt_q;
    assign bus.m_readdata = bus.s_readdata;

    // Owner mux: only the lock owner reaches the slave; everyone else stalls
    always_comb begin
        bus.s_address     = '0;
        bus.s_writedata   = '0;
        bus.s_write       = 1'b0;
        bus.s_read        = 1'b0;
        bus.m_waitrequest = '1;
        bus.m_irq         = '0;
        own_req           = 1'b0;
        own_rd            = 1'b0;
        own_wr            = 1'b0;
        for (int i = 0; i < P_NM; i++) begin
            if (own_q == P_IDXW'(i)) begin
                own_req = bus.m_req[i];
                own_rd  = bus.m_read[i];
                own_wr  = bus.m_write[i];
                if (own_en) begin
                    bus.s_address        = bus.m_address[32*i +: 32];
                    bus.s_writedata      = bus.m_writedata[32*i +: 32];
                    bus.s_write          = bus.m_write[i];
                    bus.s_read           = bus.m_read[i];
                    bus.m_waitrequest[i] = bus.s_waitrequest;
                    bus.m_irq[i]         = bus.s_interrupt;
                end
            end
        end
    end

`ifdef ECCOP_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [P_NM-1:0]  tmo_q;
    assign bus.m_timeout = tmo_q;
    // Lock FSM with idle-timeout revocation; a revoked owner parks in HOLD until it drops req
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else if (sreset) begin
            state_q <= IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            tmo_q <= '0;
            case (state_q)
                IDLE: if (pick_any) begin
                    state_q <= OWN;
                    own_q   <= pick_idx;
                    gnt_q   <= P_NM'(1) << pick_idx;
                    cnt_q   <= '0;
                end
                OWN: if (rel) begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    ptr_q   <= nxt_own;
                end else if (own_rd || own_wr) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_W'(P_TIMEOUT)) begin
                    state_q <= HOLD;
                    gnt_q   <= '0;
                    tmo_q   <= P_NM'(1) << own_q;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                HOLD: if (!own_req) begin
                    state_q <= IDLE;
                    ptr_q   <= nxt_own;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign bus.m_timeout = '0;
    // Lock FSM: grant held from pick until the owner drops req with no strobe active
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else if (sreset) begin
            state_q <= IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (pick_any) begin
                    state_q <= OWN;
                    own_q   <= pick_idx;
                    gnt_q   <= P_NM'(1) << pick_idx;
                end
                OWN: if (rel) begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    ptr_q   <= nxt_own;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_eccop_amm_arb.sv
// tb_eccop_amm_arb: directed self-checking bench for the eccop_amm job-locking arbiter
module tb_eccop_amm_arb;
    logic clk = 1'b0;
    logic areset = 1'b1;
    logic sreset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    eccop_amm_arb_if #(.P_NM(2)) bus ();

    eccop_amm_arb #(.P_NM(2), .P_TIMEOUT(8)) dut (
        .clk    (clk),
        .areset (areset),
        .sreset (sreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.m_req = '0;
        bus.m_address = '0;
        bus.m_writedata = '0;
        bus.m_write = '0;
        bus.m_read = '0;
        bus.s_waitrequest = 1'b0;
        bus.s_readdata = '0;
        bus.s_interrupt = 1'b0;
        step();
        step();
        chk("rst_gnt", 32'(bus.m_gnt), 32'h0);
        chk("rst_wait", 32'(bus.m_waitrequest), 32'h3);
        chk("rst_sread", 32'(bus.s_read), 32'h0);
        chk("rst_swrite", 32'(bus.s_write), 32'h0);
        chk("rst_irq", 32'(bus.m_irq), 32'h0);
        chk("rst_tmo", 32'(bus.m_timeout), 32'h0);
        areset = 1'b0;
        step();
        // T1: single requester, 1-cycle grant, read stalled 3 cycles
        bus.m_req = 2'b01;
        step();
        chk("t1_gnt", 32'(bus.m_gnt), 32'h1);
        bus.m_read = 2'b01;
        bus.m_address[31:0] = 32'h40;
        bus.s_waitrequest = 1'b1;
        bus.s_readdata = 32'hDEADBEEF;
        #1;
        chk("t1_sread", 32'(bus.s_read), 32'h1);
        chk("t1_saddr", bus.s_address, 32'h40);
        chk("t1_wait_c1", 32'(bus.m_waitrequest), 32'h3);
        step();
        chk("t1_wait_c2", 32'(bus.m_waitrequest), 32'h3);
        step();
        chk("t1_wait_c3", 32'(bus.m_waitrequest), 32'h3);
        bus.s_waitrequest = 1'b0;
        #1;
        chk("t1_wait_done", 32'(bus.m_waitrequest), 32'h2);
        chk("t1_rdata", bus.m_readdata, 32'hDEADBEEF);
        step();
        bus.m_read = '0;
        bus.m_req = '0;
        bus.s_readdata = '0;
        step();
        chk("t1_release", 32'(bus.m_gnt), 32'h0);
        chk("t1_idle_saddr", bus.s_address, 32'h0);
        chk("t1_idle_sread", 32'(bus.s_read), 32'h0);
        // Synchronous reset brings ptr back to 0
        sreset = 1'b1;
        step();
        sreset = 1'b0;
        chk("sreset_gnt", 32'(bus.m_gnt), 32'h0);
        // T2: both request from ptr=0, handoff through one IDLE cycle
        bus.m_req = 2'b11;
        step();
        chk("t2_gnt0", 32'(bus.m_gnt), 32'h1);
        bus.m_req = 2'b10;
        step();
        chk("t2_gap", 32'(bus.m_gnt), 32'h0);
        step();
        chk("t2_gnt1", 32'(bus.m_gnt), 32'h2);
        bus.m_req = 2'b00;
        step();
        chk("t2_rel1", 32'(bus.m_gnt), 32'h0);
        bus.m_req = 2'b11;
        step();
        chk("t2_ptr0", 32'(bus.m_gnt), 32'h1);
        bus.m_req = 2'b00;
        step();
        chk("t2_rel0", 32'(bus.m_gnt), 32'h0);
        // T3: req drop during a stalled write is deferred until the strobe drops
        bus.m_req = 2'b01;
        step();
        chk("t3_gnt", 32'(bus.m_gnt), 32'h1);
        bus.m_req = 2'b00;
        bus.m_write = 2'b01;
        bus.m_address[31:0] = 32'h8;
        bus.m_writedata[31:0] = 32'h1234;
        bus.s_waitrequest = 1'b1;
        #1;
        chk("t3_swrite", 32'(bus.s_write), 32'h1);
        chk("t3_wdata", bus.s_writedata, 32'h1234);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_hold", 32'(bus.m_gnt), 32'h1);
        end
        bus.s_waitrequest = 1'b0;
        step();
        chk("t3_accept", 32'(bus.m_gnt), 32'h1);
        bus.m_write = '0;
        step();
        chk("t3_release", 32'(bus.m_gnt), 32'h0);
        // T4: irq routing to owner 1, non-owner stalled
        bus.m_req = 2'b10;
        bus.m_address[63:32] = 32'h77;
        step();
        chk("t4_gnt", 32'(bus.m_gnt), 32'h2);
        bus.s_interrupt = 1'b1;
        #1;
        chk("t4_irq", 32'(bus.m_irq), 32'h2);
        bus.m_req = 2'b11;
        bus.m_write = 2'b01;
        bus.m_address[31:0] = 32'h99;
        #1;
        chk("t4_nonown_swrite", 32'(bus.s_write), 32'h0);
        chk("t4_nonown_wait", 32'(bus.m_waitrequest), 32'h1);
        chk("t4_saddr_owner", bus.s_address, 32'h77);
        step();
        chk("t4_misuse_gnt", 32'(bus.m_gnt), 32'h2);
        bus.m_req = 2'b00;
        bus.m_write = 2'b00;
        step();
        chk("t4_release", 32'(bus.m_gnt), 32'h0);
        chk("t4_irq_off", 32'(bus.m_irq), 32'h0);
        bus.s_interrupt = 1'b0;
`ifdef ECCOP_ARB_TIMEOUT_EN
        // T5: counter 0..8 while idle, revocation on the edge after it reaches 8
        bus.m_req = 2'b01;
        step();
        chk("t5_gnt", 32'(bus.m_gnt), 32'h1);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t5_still", 32'(bus.m_gnt), 32'h1);
            chk("t5_no_tmo", 32'(bus.m_timeout), 32'h0);
        end
        step();
        chk("t5_revoked", 32'(bus.m_gnt), 32'h0);
        chk("t5_pulse", 32'(bus.m_timeout), 32'h1);
        step();
        chk("t5_pulse_end", 32'(bus.m_timeout), 32'h0);
        step();
        chk("t5_hold", 32'(bus.m_gnt), 32'h0);
        bus.m_req = 2'b00;
        step();
        bus.m_req = 2'b01;
        step();
        chk("t5_regrant", 32'(bus.m_gnt), 32'h1);
        bus.m_req = 2'b00;
        step();
        chk("t5_release", 32'(bus.m_gnt), 32'h0);
`endif
        // T6: asynchronous reset mid-transfer
        bus.m_req = 2'b01;
        step();
        chk("t6_gnt", 32'(bus.m_gnt), 32'h1);
        bus.m_read = 2'b01;
        bus.s_waitrequest = 1'b1;
        #1;
        chk("t6_sread", 32'(bus.s_read), 32'h1);
        #1;
        areset = 1'b1;
        #1;
        chk("t6_gnt_rst", 32'(bus.m_gnt), 32'h0);
        chk("t6_sread_rst", 32'(bus.s_read), 32'h0);
        chk("t6_swrite_rst", 32'(bus.s_write), 32'h0);
        chk("t6_wait_rst", 32'(bus.m_waitrequest), 32'h3);
        bus.m_req = '0;
        bus.m_read = '0;
        bus.s_waitrequest = 1'b0;
        step();
        areset = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
